multiboot_sequencer: RTL

//  Parametrised ICAP16 warm-reboot sequencer for Spartan-6 multiboot. Maps a core slot number to an SPI

---
 rtl/multiboot_sequencer_if.sv | 26 ++
 rtl/multiboot_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multiboot_sequencer_if.sv
// Core-select / request inputs and ICAP / status outputs of the multiboot sequencer.
// master = the side driving select and requests, slave = the sequencer itself.
interface multiboot_sequencer_if;
  logic        sel_we;
  logic [7:0]  sel_core;
  logic        reboot_req;
  logic        golden_req;
  logic        icap_ce;
  logic        icap_wr;
  logic [15:0] icap_din;
  logic [23:0] spi_addr;
  logic        sel_valid;
  logic        bad_slot;
  logic        busy;
  logic        done;

  modport master (
    output sel_we, sel_core, reboot_req, golden_req,
    input  icap_ce, icap_wr, icap_din, spi_addr, sel_valid, bad_slot, busy, done
  );

  modport slave (
    input  sel_we, sel_core, reboot_req, golden_req,
    output icap_ce, icap_wr, icap_din, spi_addr, sel_valid, bad_slot, busy, done
  );
endinterface

// File: rtl/multiboot_sequencer.sv
// Spartan-6 ICAP16 warm-reboot sequencer: slot -> SPI address mapping over two flash banks,
// release-triggered request filtering, and the IPROG word stream with byte-wise bit reversal.
module multiboot_sequencer #(
  parameter int          NUM_SLOTS   = 46,
  parameter int          BANK2_FIRST = 10,
  parameter logic [23:0] SLOT_STRIDE = 24'h054000,
  parameter logic [23:0] BANK1_BASE  = 24'h004000,
  parameter logic [23:0] BANK2_BASE  = 24'h400000,
  parameter bit          QUAD_MODE   = 1'b1,
  parameter int          NOOP_COUNT  = 4,
  parameter int          FILTER      = 3
) (
  input logic                  clk_icap,
  input logic                  reset,
  multiboot_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, SYNC1, SYNC2, CMD1, NUL, GEN1H, GEN1D, GEN2H, GEN2D,
    MODEH, MODED, CMD2, RBT, NOOP
  } state_t;

  localparam logic [7:0] SLOT_LIMIT = 8'(NUM_SLOTS);
  localparam logic [7:0] B2_FIRST   = 8'(BANK2_FIRST);
  localparam logic [3:0] NOOP_INIT  = 4'(NOOP_COUNT);
  localparam logic [7:0] READ_OP    = QUAD_MODE ? 8'h6B : 8'h03;

  // Flash address of a slot; slot 0 is the golden image at the bottom of bank 1.
  function automatic logic [23:0] slot_addr(input logic [7:0] n);
    logic [23:0] idx;
    if (n == 8'd0) begin
      return 24'd0;
    end else if (n < B2_FIRST) begin
      idx = {16'd0, n};
      return SLOT_STRIDE * idx + BANK1_BASE;
    end else begin
      idx = {16'd0, n - B2_FIRST};
      return SLOT_STRIDE * idx + BANK2_BASE;
    end
  endfunction

  // ICAP expects each byte bit-reversed relative to the configuration word.
  function automatic logic [15:0] swap_bits(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7-i];
      r[8+i]   = w[15-i];
    end
    return r;
  endfunction

  state_t        state, nstate;
  logic [1:0]    r_sync, g_sync;
  logic [FILTER:0] r_hist, g_hist;
  logic          trig_r, trig_g, start;
  logic [23:0]   seq_addr;
  logic [3:0]    noop_cnt;
  logic [23:0]   spi_addr_q;
  logic          sel_valid_q, bad_slot_q;
  logic          busy_q, done_pre, done_q;
  logic          ce_n, ce_q, wr_q;
  logic [15:0]   word, din_q;

  // Two-flop synchronisers feeding a shift history of settled request samples.
  always_ff @(posedge clk_icap or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      g_sync <= '0;
      r_hist <= '0;
      g_hist <= '0;
    end else begin
      r_sync <= {r_sync[0], bus.reboot_req};
      g_sync <= {g_sync[0], bus.golden_req};
      r_hist <= {r_hist[FILTER-1:0], r_sync[1]};
      g_hist <= {g_hist[FILTER-1:0], g_sync[1]};
    end
  end

  // A request counts on release: one high sample followed by FILTER low ones.
  // The pattern exists for exactly one cycle, so this is already a single pulse.
  assign trig_r = r_hist[FILTER] & ~(|r_hist[FILTER-1:0]);
  assign trig_g = g_hist[FILTER] & ~(|g_hist[FILTER-1:0]);
  assign start  = (state == IDLE) && (trig_g || (trig_r && sel_valid_q));

  // Slot select: only accepted while idle so an in-flight sequence keeps its target.
  always_ff @(posedge clk_icap or posedge reset) begin
    if (reset) begin
      spi_addr_q  <= '0;
      sel_valid_q <= 1'b0;
      bad_slot_q  <= 1'b0;
    end else begin
      bad_slot_q <= 1'b0;
      if (state == IDLE && bus.sel_we) begin
        if (bus.sel_core < SLOT_LIMIT) begin
          spi_addr_q  <= slot_addr(bus.sel_core);
          sel_valid_q <= 1'b1;
        end else begin
          bad_slot_q  <= 1'b1;
        end
      end
    end
  end

  // Snapshot of the boot address and the NOOP tail counter.
  always_ff @(posedge clk_icap or posedge reset) begin
    if (reset) begin
      seq_addr <= '0;
      noop_cnt <= '0;
    end else begin
      if (start) seq_addr <= trig_g ? 24'd0 : spi_addr_q;
      if (state == RBT)       noop_cnt <= NOOP_INIT;
      else if (state == NOOP) noop_cnt <= noop_cnt - 4'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_icap or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // FSM next state: one configuration word per cycle, MODE pair only in quad mode.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = SYNC1;
      SYNC1:   nstate = SYNC2;
      SYNC2:   nstate = CMD1;
      CMD1:    nstate = NUL;
      NUL:     nstate = GEN1H;
      GEN1H:   nstate = GEN1D;
      GEN1D:   nstate = GEN2H;
      GEN2H:   nstate = GEN2D;
      GEN2D:   nstate = QUAD_MODE ? MODEH : CMD2;
      MODEH:   nstate = MODED;
      MODED:   nstate = CMD2;
      CMD2:    nstate = RBT;
      RBT:     nstate = NOOP;
      NOOP:    if (noop_cnt == 4'd1) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // FSM outputs: configuration word for the current state, strobes idle high.
  always_comb begin
    word = 16'hFFFF;
    ce_n = 1'b0;
    unique case (state)
      IDLE:    ce_n = 1'b1;
      SYNC1:   word = 16'hAA99;
      SYNC2:   word = 16'h5566;
      CMD1:    word = 16'h30A1;
      NUL:     word = 16'h0000;
      GEN1H:   word = 16'h3261;
      GEN1D:   word = seq_addr[15:0];
      GEN2H:   word = 16'h3281;
      GEN2D:   word = {READ_OP, seq_addr[23:16]};
      MODEH:   word = 16'h3301;
      MODED:   word = 16'h3100;
      CMD2:    word = 16'h30A1;
      RBT:     word = 16'h000E;
      NOOP:    word = 16'h2000;
      default: ce_n = 1'b1;
    endcase
  end

  // ICAP pins registered one cycle behind the FSM.
  always_ff @(posedge clk_icap or posedge reset) begin
    if (reset) begin
      ce_q  <= 1'b1;
      wr_q  <= 1'b1;
      din_q <= 16'hFFFF;
    end else begin
      ce_q  <= ce_n;
      wr_q  <= ce_n;
      din_q <= swap_bits(word);
    end
  end

  // busy tracks the FSM state; done follows the last NOOP word off the pins.
  always_ff @(posedge clk_icap or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      done_pre <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q   <= (nstate != IDLE);
      done_pre <= (state == NOOP) && (nstate == IDLE);
      done_q   <= done_pre;
    end
  end

  assign bus.icap_ce   = ce_q;
  assign bus.icap_wr   = wr_q;
  assign bus.icap_din  = din_q;
  assign bus.spi_addr  = spi_addr_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.bad_slot  = bad_slot_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
